// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller that turns EX/MEM load/store requests
// into a handshaked data-cache access, stalls the pipeline until the cache
// answers (or the watchdog expires), captures load data and latches halt.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTW    = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            memcuDRE,
  input  logic            memcuDWE,
  input  logic            memcuHALT,
  input  logic [31:0]     memOutput_Port,
  input  logic [31:0]     memrdat2,
  input  logic            dhit,
  input  logic [31:0]     dmemload,
  output logic            dmemREN,
  output logic            dmemWEN,
  output logic [31:0]     dmemaddr,
  output logic [31:0]     dmemstore,
  output logic            memstall,
  output logic [31:0]     ldata,
  output logic            halt,
  output logic            err,
  output logic [CNTW-1:0] stallcnt
);

  // Watchdog counter only needs to hold 0 .. TIMEOUT-1.
  localparam int unsigned    WDW     = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);
  localparam bit             WD_EN   = (TIMEOUT != 0);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_capture;
  logic            w_hit;
  logic            w_expire;
  logic            w_memstall;
  logic            w_req;

  logic [31:0]     r_addr;
  logic [31:0]     r_store;
  logic [31:0]     r_ldata;
  logic            r_is_wr;
  logic            r_err;
  logic            r_halt;
  logic [WDW-1:0]  r_wdog;
  logic [CNTW-1:0] r_cnt;

  assign w_req = memcuDRE | memcuDWE;

  // State register; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus request/stall outputs derived from the state.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_hit      = 1'b0;
    w_expire   = 1'b0;
    w_memstall = 1'b0;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (memcuHALT) begin
          w_next = S_HALTED;
        end else if (w_req) begin
          w_next     = S_ACCESS;
          w_capture  = 1'b1;
          w_memstall = 1'b1;
        end
      end
      S_ACCESS: begin
        w_memstall = 1'b1;
        dmemREN    = ~r_is_wr;
        dmemWEN    = r_is_wr;
        if (dhit) begin
          w_next = S_DONE;
          w_hit  = 1'b1;
        end else if (WD_EN && (r_wdog == WD_LAST)) begin
          w_next   = S_DONE;
          w_expire = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      S_HALTED: begin
        w_memstall = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign memstall = w_memstall;

  // Request capture: address/data/kind are frozen for the whole access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr  <= 32'd0;
      r_store <= 32'd0;
      r_is_wr <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= memOutput_Port;
      r_store <= memrdat2;
      r_is_wr <= memcuDWE;
    end
  end

  // Load data is updated only by a load hit; a timeout leaves it untouched.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ldata <= 32'd0;
    end else if (w_hit && !r_is_wr) begin
      r_ldata <= dmemload;
    end
  end

  // Watchdog: counts consecutive ACCESS cycles, cleared on leaving ACCESS.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wdog <= '0;
    end else if ((r_state == S_ACCESS) && (w_next == S_ACCESS)) begin
      r_wdog <= r_wdog + WDW'(1);
    end else begin
      r_wdog <= '0;
    end
  end

  // Sticky error and halt flags, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_err  <= 1'b0;
      r_halt <= 1'b0;
    end else begin
      if (w_expire) begin
        r_err <= 1'b1;
      end
      if (w_next == S_HALTED) begin
        r_halt <= 1'b1;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (w_memstall && (r_cnt != {CNTW{1'b1}})) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign dmemaddr  = r_addr;
  assign dmemstore = r_store;
  assign ldata     = r_ldata;
  assign halt      = r_halt;
  assign err       = r_err;
  assign stallcnt  = r_cnt;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and randomized checks of mem_stage_ctrl against
// a transaction-level model (latency, stall length, ldata, err, stallcnt).
module tb_mem_stage_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          CLK;
  logic          nRST;
  logic          memcuDRE, memcuDWE, memcuHALT;
  logic [31:0]   memOutput_Port, memrdat2;
  logic          dhit;
  logic [31:0]   dmemload;
  logic          dmemREN, dmemWEN;
  logic [31:0]   dmemaddr, dmemstore;
  logic          memstall;
  logic [31:0]   ldata;
  logic          halt, err;
  logic [CW-1:0] stallcnt;

  int checks;
  int failures;

  // Transaction observations
  int          o_ren, o_wen, o_stall;
  bit          o_stable, o_done;
  logic [31:0] o_ldata;
  logic        o_err, o_req_done;
  logic [CW-1:0] o_cnt;

  // Reference model state
  logic [31:0] m_ldata;
  bit          m_err;
  int          m_cnt;
  int          e_ren, e_wen, e_stall;

  mem_stage_ctrl #(.TIMEOUT(TO), .CNTW(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
    .memOutput_Port(memOutput_Port), .memrdat2(memrdat2),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .memstall(memstall), .ldata(ldata),
    .halt(halt), .err(err), .stallcnt(stallcnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    memcuDRE = 1'b0; memcuDWE = 1'b0; memcuHALT = 1'b0;
    dhit = 1'b0; dmemload = 32'd0;
  endtask

  task automatic model_reset();
    m_ldata = 32'd0; m_err = 1'b0; m_cnt = 0;
  endtask

  // Reset pulse; returns just after a rising edge with DUT idle.
  task automatic apply_reset();
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    model_reset();
  endtask

  // Model: access length is the hit cycle, capped at TO (then it is a timeout).
  task automatic model_txn(input bit re, input bit we, input int lat, input logic [31:0] lv);
    int  acc;
    bit  tmo;
    tmo = !(lat >= 1 && lat <= int'(TO));
    acc = tmo ? int'(TO) : lat;
    e_stall = 1 + acc;
    e_wen   = we ? acc : 0;
    e_ren   = (re && !we) ? acc : 0;
    if (re && !we && !tmo) m_ldata = lv;
    if (tmo) m_err = 1'b1;
    m_cnt = (m_cnt + e_stall > CMAX) ? CMAX : m_cnt + e_stall;
  endtask

  // Issue one request from IDLE and observe it until memstall drops (DONE).
  task automatic run_txn(input bit re, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input int lat, input logic [31:0] lv);
    memcuDRE = re; memcuDWE = we; memcuHALT = 1'b0;
    memOutput_Port = a; memrdat2 = d;
    dhit = 1'($urandom_range(0, 1));
    dmemload = $urandom;
    o_ren = 0; o_wen = 0; o_stall = 0; o_stable = 1'b1; o_done = 1'b0;
    o_ldata = 'x; o_err = 1'bx; o_cnt = 'x; o_req_done = 1'bx;
    @(negedge CLK);
    if (memstall) o_stall++;
    for (int c = 1; c <= 20 && !o_done; c++) begin
      @(posedge CLK);
      #1;
      dhit = (c == lat);
      dmemload = (c == lat) ? lv : $urandom;
      memOutput_Port = $urandom;
      memrdat2 = $urandom;
      @(negedge CLK);
      if (memstall) begin
        o_stall++;
        if (dmemREN) o_ren++;
        if (dmemWEN) o_wen++;
        if (dmemaddr !== a || dmemstore !== d) o_stable = 1'b0;
      end else begin
        o_done = 1'b1;
        o_ldata = ldata; o_err = err; o_cnt = stallcnt;
        o_req_done = dmemREN | dmemWEN;
      end
    end
    @(posedge CLK);
    #1 idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    memOutput_Port = 32'd0; memrdat2 = 32'd0;
    nRST = 1'b0;
    #1;
    checks++;
    if ({dmemREN, dmemWEN, memstall, halt, err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {dmemREN, dmemWEN, memstall, halt, err});
    end
    checks++;
    if (dmemaddr !== 32'd0 || dmemstore !== 32'd0 || ldata !== 32'd0 || stallcnt !== '0) begin
      failures++; $display("FAIL reset_data got addr=%h store=%h ldata=%h cnt=%h exp all 0", dmemaddr, dmemstore, ldata, stallcnt);
    end
    apply_reset();
  endtask

  task automatic test_load();
    run_txn(1'b1, 1'b0, 32'h40, 32'h0BAD_F00D, 1, 32'hDEADBEEF);
    model_txn(1'b1, 1'b0, 1, 32'hDEADBEEF);
    checks++;
    if (!o_done) begin failures++; $display("FAIL load_done got=0 exp=1"); end
    checks++;
    if (o_ren !== 1 || o_wen !== 0) begin
      failures++; $display("FAIL load_req got ren=%0d wen=%0d exp ren=1 wen=0", o_ren, o_wen);
    end
    checks++;
    if (!o_stable) begin failures++; $display("FAIL load_addr got unstable exp dmemaddr=00000040"); end
    checks++;
    if (o_ldata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_ldata got=%h exp=deadbeef", o_ldata); end
    checks++;
    if (o_stall !== 2) begin failures++; $display("FAIL load_stall got=%0d exp=2", o_stall); end
    checks++;
    if (o_cnt !== CW'(2)) begin failures++; $display("FAIL load_stallcnt got=%0d exp=2", o_cnt); end
    checks++;
    if (o_req_done !== 1'b0) begin failures++; $display("FAIL load_done_req got=%b exp=0", o_req_done); end
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, 32'h80, 32'h12345678, 3, $urandom);
    model_txn(1'b0, 1'b1, 3, 32'd0);
    checks++;
    if (o_wen !== 3 || o_ren !== 0) begin
      failures++; $display("FAIL store_req got wen=%0d ren=%0d exp wen=3 ren=0", o_wen, o_ren);
    end
    checks++;
    if (!o_stable) begin failures++; $display("FAIL store_stable got unstable exp addr=80 data=12345678"); end
    checks++;
    if (o_stall !== 4) begin failures++; $display("FAIL store_stall got=%0d exp=4", o_stall); end
    checks++;
    if (o_ldata !== m_ldata) begin failures++; $display("FAIL store_ldata got=%h exp=%h", o_ldata, m_ldata); end
    checks++;
    if (o_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL store_stallcnt got=%0d exp=%0d", o_cnt, m_cnt); end
  endtask

  task automatic test_both();
    run_txn(1'b1, 1'b1, 32'h100, 32'hCAFE0001, 2, $urandom);
    model_txn(1'b1, 1'b1, 2, 32'd0);
    checks++;
    if (o_ren !== 0 || o_wen !== 2) begin
      failures++; $display("FAIL both_req got ren=%0d wen=%0d exp ren=0 wen=2", o_ren, o_wen);
    end
    checks++;
    if (o_ldata !== m_ldata) begin failures++; $display("FAIL both_ldata got=%h exp=%h", o_ldata, m_ldata); end
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 32'h200, 32'd0, 9, 32'h55555555);
    model_txn(1'b1, 1'b0, 9, 32'h55555555);
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", o_err); end
    checks++;
    if (o_ren !== int'(TO) || o_stall !== int'(TO) + 1) begin
      failures++; $display("FAIL tmo_len got ren=%0d stall=%0d exp ren=%0d stall=%0d", o_ren, o_stall, TO, TO + 1);
    end
    checks++;
    if (o_ldata !== m_ldata) begin failures++; $display("FAIL tmo_ldata got=%h exp=%h", o_ldata, m_ldata); end
    @(negedge CLK);
    checks++;
    if (memstall !== 1'b0 || err !== 1'b1) begin
      failures++; $display("FAIL tmo_idle got stall=%b err=%b exp stall=0 err=1", memstall, err);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid_access();
    memcuDRE = 1'b1; memOutput_Port = 32'h44; memrdat2 = 32'h99;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (dmemREN !== 1'b1) begin failures++; $display("FAIL rst_pre_ren got=%b exp=1", dmemREN); end
    #1 nRST = 1'b0; memcuDRE = 1'b0;
    #1;
    checks++;
    if ({dmemREN, dmemWEN, memstall, halt, err} !== 5'b0) begin
      failures++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {dmemREN, dmemWEN, memstall, halt, err});
    end
    checks++;
    if (dmemaddr !== 32'd0 || dmemstore !== 32'd0 || ldata !== 32'd0 || stallcnt !== '0) begin
      failures++; $display("FAIL rst_mid_data got addr=%h store=%h ldata=%h cnt=%h exp all 0", dmemaddr, dmemstore, ldata, stallcnt);
    end
    @(posedge CLK);
    #1 nRST = 1'b1;
    model_reset();
  endtask

  task automatic test_halt();
    memcuHALT = 1'b1; memcuDRE = 1'b1; memOutput_Port = 32'h300;
    @(negedge CLK);
    checks++;
    if (memstall !== 1'b0 || halt !== 1'b0 || dmemREN !== 1'b0) begin
      failures++; $display("FAIL halt_first got stall=%b halt=%b ren=%b exp 0 0 0", memstall, halt, dmemREN);
    end
    @(posedge CLK);
    #1 idle_inputs();
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin memcuDRE = 1'b1; memcuDWE = 1'b1; end
      @(negedge CLK);
      checks++;
      if (halt !== 1'b1 || memstall !== 1'b1 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
        failures++; $display("FAIL halt_hold cyc=%0d got halt=%b stall=%b ren=%b wen=%b exp 1 1 0 0", k, halt, memstall, dmemREN, dmemWEN);
      end
    end
    checks++;
    if (stallcnt !== CW'(CMAX)) begin failures++; $display("FAIL halt_stallcnt_sat got=%h exp=%h", stallcnt, CMAX); end
    apply_reset();
  endtask

  task automatic test_random();
    bit re, we;
    int lat, gaps;
    logic [31:0] a, d, lv;
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        dhit = 1'($urandom_range(0, 1));
        @(negedge CLK);
        checks++;
        if (memstall !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
          failures++; $display("FAIL rnd_idle t=%0d got stall=%b ren=%b wen=%b exp 0 0 0", t, memstall, dmemREN, dmemWEN);
        end
        @(posedge CLK);
        #1 dhit = 1'b0;
      end
      do begin
        re = 1'($urandom_range(0, 1));
        we = 1'($urandom_range(0, 1));
      end while (!re && !we);
      lat = $urandom_range(1, 6);
      a = $urandom; d = $urandom; lv = $urandom;
      run_txn(re, we, a, d, lat, lv);
      model_txn(re, we, lat, lv);
      checks++;
      if (!o_done || o_ren !== e_ren || o_wen !== e_wen || o_stall !== e_stall) begin
        failures++;
        $display("FAIL rnd_seq t=%0d got done=%b ren=%0d wen=%0d stall=%0d exp done=1 ren=%0d wen=%0d stall=%0d",
                 t, o_done, o_ren, o_wen, o_stall, e_ren, e_wen, e_stall);
      end
      checks++;
      if (!o_stable) begin failures++; $display("FAIL rnd_stable t=%0d got unstable exp addr=%h data=%h", t, a, d); end
      checks++;
      if (o_ldata !== m_ldata || o_err !== m_err || o_cnt !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL rnd_state t=%0d got ldata=%h err=%b cnt=%0d exp ldata=%h err=%b cnt=%0d",
                 t, o_ldata, o_err, o_cnt, m_ldata, m_err, m_cnt);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_load();
    test_store();
    test_both();
    test_timeout();
    test_reset_mid_access();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
